mul_div_unit: RTL

//   Multi-cycle multiply/divide responder driven by the EX stage (start/func/busy/HI/LO).

---
 rtl/mul_div_unit.sv | 133 +++++++++++++
 1 files changed

// File: rtl/mul_div_unit.sv
// mul_div_unit: multi-cycle multiply/divide unit owning the architectural HI/LO pair.
//   A request (start + func) taken while idle computes its 64-bit result up front
//   into a pending register, then holds busy for a fixed latency before committing
//   it to HI/LO. MTHI/MTLO write HI/LO directly with no latency.
// Ports:
//   clk, rst_n   clock (rising edge), asynchronous active-low reset
//   A, B         32-bit operands, captured when start is accepted
//   start, func  request strobe and 4-bit function code
//   busy         operation in flight; HI/LO not yet updated
//   HI, LO       architectural HI/LO registers
module mul_div_unit #(
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        start,
  input  logic [3:0]  func,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam logic [3:0] F_MULT  = 4'd1, F_MULTU = 4'd2, F_DIV  = 4'd3, F_DIVU  = 4'd4,
                         F_MTHI  = 4'd5, F_MTLO  = 4'd6, F_MADD = 4'd7, F_MADDU = 4'd8,
                         F_MSUB  = 4'd9, F_MSUBU = 4'd10;

  typedef enum logic {S_IDLE, S_RUN} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] ph_q, ph_d, pl_q, pl_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;

  // Shared multiplier: operands sign- or zero-extended to 64 bits, low 64 bits kept.
  logic        mul_sgn;
  logic [63:0] mul_a, mul_b, prod, acc;

  // Shared divider working on magnitudes; signs are reapplied afterwards so the
  // 0x80000000 / -1 case falls out naturally (magnitude 2^31 negates to itself).
  logic        div_sgn, a_neg, b_neg;
  logic [31:0] dvd, dvs, uq, ur, quo, rem;

  always_comb begin
    mul_sgn = (func == F_MULT) || (func == F_MADD) || (func == F_MSUB);
    mul_a   = {{32{mul_sgn & A[31]}}, A};
    mul_b   = {{32{mul_sgn & B[31]}}, B};
    prod    = mul_a * mul_b;
    acc     = {hi_q, lo_q};

    div_sgn = (func == F_DIV);
    a_neg   = div_sgn & A[31];
    b_neg   = div_sgn & B[31];
    dvd     = a_neg ? -A : A;
    dvs     = b_neg ? -B : B;
    if (dvs == 32'd0) dvs = 32'd1;  // result unused on divide-by-zero
    uq      = dvd / dvs;
    ur      = dvd % dvs;
    quo     = (a_neg ^ b_neg) ? -uq : uq;
    rem     = a_neg ? -ur : ur;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ph_d    = ph_q;
    pl_d    = pl_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    if (state_q == S_RUN) begin
      // Requests arriving while busy are dropped.
      cnt_d = cnt_q - 4'd1;
      if (cnt_q == 4'd1) begin
        state_d = S_IDLE;
        hi_d    = ph_q;
        lo_d    = pl_q;
      end
    end else if (start) begin
      unique case (func)
        F_MULT, F_MULTU: begin
          {ph_d, pl_d} = prod;
          cnt_d   = 4'(MUL_CYCLES);
          state_d = S_RUN;
        end
        F_MADD, F_MADDU: begin
          {ph_d, pl_d} = acc + prod;
          cnt_d   = 4'(MUL_CYCLES);
          state_d = S_RUN;
        end
        F_MSUB, F_MSUBU: begin
          {ph_d, pl_d} = acc - prod;
          cnt_d   = 4'(MUL_CYCLES);
          state_d = S_RUN;
        end
        F_DIV, F_DIVU: begin
          // Divide-by-zero still takes the full latency but commits the old HI/LO.
          if (B == 32'd0) {ph_d, pl_d} = acc;
          else            {ph_d, pl_d} = {rem, quo};
          cnt_d   = 4'(DIV_CYCLES);
          state_d = S_RUN;
        end
        F_MTHI:  hi_d = A;
        F_MTLO:  lo_d = A;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      ph_q    <= 32'd0;
      pl_q    <= 32'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ph_q    <= ph_d;
      pl_q    <= pl_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign busy = (state_q == S_RUN);
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule
